// File: rtl/soc_decerr_slave_if.sv
// soc_decerr_slave_if: AXI4 AW/W/B/AR/R subset seen by the default error slave.
// Ports: AW (valid/ready/id/addr), W (valid/ready/last), B (valid/ready/id/resp),
//        AR (valid/ready/id/addr/len), R (valid/ready/id/data/resp/last).
// Suffixes follow the slave's view: _i is driven by the master, _o by the slave.
interface soc_decerr_slave_if #(
    parameter int unsigned IdWidth   = 8,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64
);
    logic                 aw_valid_i;
    logic                 aw_ready_o;
    logic [IdWidth-1:0]   aw_id_i;
    logic [AddrWidth-1:0] aw_addr_i;
    logic                 w_valid_i;
    logic                 w_ready_o;
    logic                 w_last_i;
    logic                 b_valid_o;
    logic                 b_ready_i;
    logic [IdWidth-1:0]   b_id_o;
    logic [1:0]           b_resp_o;
    logic                 ar_valid_i;
    logic                 ar_ready_o;
    logic [IdWidth-1:0]   ar_id_i;
    logic [AddrWidth-1:0] ar_addr_i;
    logic [7:0]           ar_len_i;
    logic                 r_valid_o;
    logic                 r_ready_i;
    logic [IdWidth-1:0]   r_id_o;
    logic [DataWidth-1:0] r_data_o;
    logic [1:0]           r_resp_o;
    logic                 r_last_o;

    modport slave (
        input  aw_valid_i, aw_id_i, aw_addr_i, w_valid_i, w_last_i, b_ready_i,
               ar_valid_i, ar_id_i, ar_addr_i, ar_len_i, r_ready_i,
        output aw_ready_o, w_ready_o, b_valid_o, b_id_o, b_resp_o,
               ar_ready_o, r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o
    );

    modport master (
        output aw_valid_i, aw_id_i, aw_addr_i, w_valid_i, w_last_i, b_ready_i,
               ar_valid_i, ar_id_i, ar_addr_i, ar_len_i, r_ready_i,
        input  aw_ready_o, w_ready_o, b_valid_o, b_id_o, b_resp_o,
               ar_ready_o, r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o
    );
endinterface

// File: rtl/soc_decerr_slave.sv
// soc_decerr_slave: AXI4 default slave answering every request with DECERR.
// Ports: clk_i, rst_ni (async active-low); axi (slave modport, AXI bus);
//        err_valid_o/err_addr_o/err_write_o sticky first-fault record,
//        err_cnt_o saturating fault count, clr_i clears both, irq_o capture pulse.
module soc_decerr_slave #(
    parameter int unsigned          IdWidth   = 8,
    parameter int unsigned          AddrWidth = 64,
    parameter int unsigned          DataWidth = 64,
    parameter logic [DataWidth-1:0] RespData  = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    soc_decerr_slave_if.slave    axi,
    output logic                 err_valid_o,
    output logic [AddrWidth-1:0] err_addr_o,
    output logic                 err_write_o,
    output logic [15:0]          err_cnt_o,
    input  logic                 clr_i,
    output logic                 irq_o
);
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e             w_state_q, w_state_d;
    r_state_e             r_state_q, r_state_d;
    logic [IdWidth-1:0]   b_id_q, b_id_d, r_id_q, r_id_d;
    logic [7:0]           r_cnt_q, r_cnt_d;
    logic                 err_valid_q, err_valid_d, err_write_q, err_write_d, irq_q, irq_d;
    logic [AddrWidth-1:0] err_addr_q, err_addr_d;
    logic [15:0]          err_cnt_q, err_cnt_d;
    logic                 aw_hs, ar_hs, valid_base;
    logic [16:0]          cnt_sum;

    assign aw_hs = axi.aw_valid_i && (w_state_q == W_IDLE);
    assign ar_hs = axi.ar_valid_i && (r_state_q == R_IDLE);

    always_comb begin
        w_state_d = w_state_q;
        b_id_d    = b_id_q;
        case (w_state_q)
            W_IDLE: if (axi.aw_valid_i) begin
                w_state_d = W_DATA;
                b_id_d    = axi.aw_id_i;
            end
            W_DATA:  if (axi.w_valid_i && axi.w_last_i) w_state_d = W_RESP;
            W_RESP:  if (axi.b_ready_i) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_cnt_d   = r_cnt_q;
        case (r_state_q)
            R_IDLE: if (axi.ar_valid_i) begin
                r_state_d = R_DATA;
                r_id_d    = axi.ar_id_i;
                r_cnt_d   = axi.ar_len_i;
            end
            default: if (axi.r_ready_i) begin
                r_state_d = (r_cnt_q == 8'd0) ? R_IDLE : R_DATA;
                r_cnt_d   = (r_cnt_q == 8'd0) ? r_cnt_q : r_cnt_q - 8'd1;
            end
        endcase
    end

    // Clear is applied before the new fault so a simultaneous fault reloads the record.
    always_comb begin
        valid_base  = clr_i ? 1'b0 : err_valid_q;
        cnt_sum     = {1'b0, clr_i ? 16'd0 : err_cnt_q} + 17'({1'b0, aw_hs} + {1'b0, ar_hs});
        err_cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        irq_d       = (aw_hs || ar_hs) && !valid_base;
        err_valid_d = valid_base || irq_d;
        err_addr_d  = irq_d ? (aw_hs ? axi.aw_addr_i : axi.ar_addr_i) : (clr_i ? '0 : err_addr_q);
        err_write_d = irq_d ? aw_hs : (clr_i ? 1'b0 : err_write_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            b_id_q      <= '0;
            r_id_q      <= '0;
            r_cnt_q     <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_write_q <= 1'b0;
            err_cnt_q   <= '0;
            irq_q       <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            b_id_q      <= b_id_d;
            r_id_q      <= r_id_d;
            r_cnt_q     <= r_cnt_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            err_write_q <= err_write_d;
            err_cnt_q   <= err_cnt_d;
            irq_q       <= irq_d;
        end
    end

    // All bus outputs are pure decodes of registered state, so no valid->ready paths exist.
    assign axi.aw_ready_o = (w_state_q == W_IDLE);
    assign axi.w_ready_o  = (w_state_q == W_DATA);
    assign axi.b_valid_o  = (w_state_q == W_RESP);
    assign axi.b_resp_o   = axi.b_valid_o ? 2'b11 : 2'b00;
    assign axi.b_id_o     = b_id_q;
    assign axi.ar_ready_o = (r_state_q == R_IDLE);
    assign axi.r_valid_o  = (r_state_q == R_DATA);
    assign axi.r_resp_o   = axi.r_valid_o ? 2'b11 : 2'b00;
    assign axi.r_data_o   = axi.r_valid_o ? RespData : '0;
    assign axi.r_last_o   = axi.r_valid_o && (r_cnt_q == 8'd0);
    assign axi.r_id_o     = r_id_q;
    assign err_valid_o    = err_valid_q;
    assign err_addr_o     = err_addr_q;
    assign err_write_o    = err_write_q;
    assign err_cnt_o      = err_cnt_q;
    assign irq_o          = irq_q;
endmodule

// File: doc/soc_decerr_slave.md
# soc_decerr_slave

AXI4 default (error) slave for the SoC crossbar: terminates every request whose address matches none of the SoC address-map rules (Debug … HYAXI) and returns spec-compliant DECERR responses so masters never hang. It also captures the first faulting address in a sticky record, keeps a saturating error count, and pulses an interrupt line routed to the PLIC.

## Interface
- IdWidth, 8 (= IdWidthSlave, 5 + clog2(8)), AXI ID width on the crossbar master side
- AddrWidth, 64, AXI address width
- DataWidth, 64, AXI data width
- RespData, 64'hDEAD_BEEF_DEAD_BEEF, constant RDATA for every error beat
- clk_i  in  1  SoC clock
- rst_ni  in  1  asynchronous active-low reset
- aw_valid_i / aw_ready_o  in/out  1  AW handshake; aw_id_i in IdWidth, aw_addr_i in AddrWidth
- w_valid_i / w_ready_o  in/out  1  W handshake; w_last_i in 1 (WDATA/WSTRB ignored, not ported)
- b_valid_o / b_ready_i  out/in  1  B handshake; b_id_o out IdWidth, b_resp_o out 2
- ar_valid_i / ar_ready_o  in/out  1  AR handshake; ar_id_i in IdWidth, ar_addr_i in AddrWidth, ar_len_i in 8
- r_valid_o / r_ready_i  out/in  1  R handshake; r_id_o out IdWidth, r_data_o out DataWidth, r_resp_o out 2, r_last_o out 1
- err_valid_o  out  1  sticky: a fault record is held
- err_addr_o  out  AddrWidth  address of the first captured fault
- err_write_o  out  1  captured fault was a write (1) or read (0)
- err_cnt_o  out  16  saturating count of all faulting transactions
- clr_i  in  1  single-cycle pulse: clear record and counter
- irq_o  out  1  one-cycle pulse when a record is captured

## Operation
- Write and read paths are independent FSMs; each holds one transaction at a time (no outstanding queue).
- Write FSM: W_IDLE (aw_ready_o=1) → on AW handshake latch aw_id_i → W_DATA (w_ready_o=1, accept and discard beats) → on W handshake with w_last_i=1 → W_RESP (b_valid_o=1, b_resp_o=2'b11, b_id_o=latched ID) → on b_ready_i → W_IDLE.
- Read FSM: R_IDLE (ar_ready_o=1) → on AR handshake latch ar_id_i, beat counter = ar_len_i → R_DATA (r_valid_o=1, r_resp_o=2'b11, r_data_o=RespData, r_id_o=latched ID, r_last_o=(counter==0)) → each R handshake decrements counter; handshake with counter==0 → R_IDLE.
- Beat counter 8 bits; ar_len_i=0 gives exactly one beat, ar_len_i=255 gives exactly 256 beats; never wraps.
- Fault capture on every AW or AR handshake: err_cnt_o increments, saturating at 16'hFFFF. If err_valid_o=0, latch address and direction, set err_valid_o, pulse irq_o next cycle. Later faults do not overwrite the record.
- AW and AR handshakes in the same cycle: counter +2 (saturating); record takes the write (write priority).
- clr_i together with a handshake: clear applies first, new fault is then captured (record loaded, counter = 1 or 2, irq_o pulses).
- W beats arriving before AW are not accepted (w_ready_o=0 outside W_DATA).
- Reset mid-transaction: both FSMs return to IDLE and in-flight beats and responses are dropped.

## Timing
- Reset values: aw_ready_o=1, ar_ready_o=1, w_ready_o=0, b_valid_o=0, r_valid_o=0, r_last_o=0, b_resp_o=r_resp_o=2'b00, ids=0, r_data_o=0, err_valid_o=0, err_addr_o=0, err_write_o=0, err_cnt_o=0, irq_o=0.
- AW handshake at cycle n → w_ready_o=1 from n+1; earliest WLAST at n+1; B valid the cycle after the WLAST handshake.
- AR handshake at cycle n → first R beat valid at n+1; with r_ready_i held high, len+1 beats on consecutive cycles.
- b_valid_o/r_valid_o and all payloads stay stable until their handshake (AXI rule); no combinational valid→ready paths.
- aw_ready_o/ar_ready_o are registered state decodes, high only in the respective IDLE state.
- err_* update the cycle after the handshake; irq_o is high for exactly one cycle.

## Test plan
- AW id=0x15 addr=0x6000_0000, 4 W beats with WLAST on the 4th → B id=0x15 resp=2'b11 one cycle after last beat; err_addr_o=0x6000_0000, err_write_o=1, irq_o one pulse, err_cnt_o=1.
- AR id=0x03 len=7 with r_ready_i toggling every cycle → exactly 8 beats, r_data_o=RespData, r_resp_o=2'b11, r_last_o only on the 8th, r_id_o=0x03.
- AW and AR in the same cycle from reset → err_cnt_o=2, err_write_o=1, single irq_o pulse, both responses complete independently.
- Second fault after first → err_addr_o unchanged, no irq_o; then clr_i simultaneous with a read fault at 0x7100_0000 → err_cnt_o=1, err_addr_o=0x7100_0000, err_write_o=0, irq_o pulses.
- Preload err_cnt_o by 65 537 faults → err_cnt_o holds 16'hFFFF.
- Assert rst_ni low during R_DATA of a len=255 burst → r_valid_o=0 immediately, all outputs at reset values, ar_ready_o=1 after release.
